video_stream_ctrl: RTL



---
 rtl/video_pkg.sv | 10 +
 rtl/spi_clk_gen.sv | 23 ++
 rtl/video_stream_ctrl.sv | 94 +++++++++
 3 files changed

// File: rtl/video_pkg.sv
// video_pkg: shared state type and frame constants for the video fetch path
package video_pkg;
  typedef enum logic [2:0] {IDLE, CMD, FILL, WAIT, DRAIN, DONE} state_t;
  localparam int CMD_BITS = 32;
  localparam int DEF_FRAME_BITS = 30000;
  localparam int DEF_NUM_FRAMES = 6572;
  function automatic int max2(input int a, input int b);
    return a > b ? a : b;
  endfunction
endpackage

// File: rtl/spi_clk_gen.sv
// spi_clk_gen: mode-0 SPI clock divider with rising/falling edge strobes
module spi_clk_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic CLK_40,
  input  logic reset,
  input  logic run,
  output logic SPI_clk,
  output logic SPI_clk_en,
  output logic fall_en
);
  localparam int CW = $clog2(CLK_DIV);
  localparam int HALF = CLK_DIV / 2;
  logic [CW-1:0] r_cnt;
  if (CLK_DIV < 2 || CLK_DIV % 2 != 0) begin : g_bad_div
    $error("spi_clk_gen: CLK_DIV must be even and >= 2");
  end
  // divider count; held at zero whenever the clock is not running
  always_ff @(posedge CLK_40) r_cnt <= (reset || !run || r_cnt == CW'(CLK_DIV - 1)) ? '0 : r_cnt + 1'b1;
  assign SPI_clk    = run && r_cnt >= CW'(HALF);
  assign SPI_clk_en = run && r_cnt == CW'(HALF - 1);
  assign fall_en    = run && r_cnt == CW'(CLK_DIV - 1);
endmodule

// File: rtl/video_stream_ctrl.sv
// video_stream_ctrl: SPI flash read sequencer pacing frame fills against the display
module video_stream_ctrl
  import video_pkg::*;
#(
  parameter int          CLK_DIV    = 4,
  parameter int          FRAME_BITS = DEF_FRAME_BITS,
  parameter int          NUM_FRAMES = DEF_NUM_FRAMES,
  parameter logic [7:0]  READ_CMD   = 8'h03,
  parameter logic [23:0] START_ADDR = 24'h000000,
  parameter int          FRAME_W    = 13
) (
  input  logic               CLK_40,
  input  logic               reset,
  input  logic               start,
  input  logic               bank_full,
  input  logic               frame_done,
  output logic               SPI_clk,
  output logic               SPI_clk_en,
  output logic               CS_N,
  output logic               MOSI,
  output logic               video_bank_we,
  output logic [FRAME_W-1:0] frame_idx,
  output logic               busy,
  output logic               done,
  output logic               overrun,
  output logic               len_err
);
  localparam int BW = $clog2(max2(FRAME_BITS, CMD_BITS) + 1);
  state_t r_state, w_state_nx;
  logic [BW-1:0] r_bit_cnt;
  logic [31:0] r_shift;
  logic [FRAME_W-1:0] r_frame_idx;
  logic r_pending, r_overrun, r_len_err;
  logic w_run, w_fall_en, w_start, w_cmd_end, w_last_bit, w_short, w_go, w_last_frame, w_next_frame;
  if (NUM_FRAMES - 1 >= (1 << FRAME_W)) begin : g_bad_w
    $error("video_stream_ctrl: FRAME_W too narrow for NUM_FRAMES-1");
  end
  assign w_run        = r_state == CMD || r_state == FILL;
  assign w_start      = start && (r_state == IDLE || r_state == DONE);
  assign w_cmd_end    = r_state == CMD && SPI_clk_en && r_bit_cnt == BW'(CMD_BITS - 1);
  assign w_last_bit   = r_state == FILL && SPI_clk_en && r_bit_cnt == BW'(FRAME_BITS - 1);
  assign w_short      = r_state == FILL && bank_full && !w_last_bit;
  assign w_go         = r_state == WAIT && (frame_done || r_pending);
  assign w_last_frame = r_frame_idx == FRAME_W'(NUM_FRAMES - 1);
  assign w_next_frame = w_go && !w_last_frame;
  spi_clk_gen #(.CLK_DIV(CLK_DIV)) u_spi_clk (
    .CLK_40(CLK_40),
    .reset(reset),
    .run(w_run),
    .SPI_clk(SPI_clk),
    .SPI_clk_en(SPI_clk_en),
    .fall_en(w_fall_en)
  );
  // state register
  always_ff @(posedge CLK_40) r_state <= reset ? IDLE : w_state_nx;
  // next-state: CS_N stays low through WAIT so the flash read resumes seamlessly
  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      IDLE, DONE: w_state_nx = start ? CMD : r_state;
      CMD:        w_state_nx = w_cmd_end ? FILL : CMD;
      FILL:       w_state_nx = (w_last_bit || w_short) ? WAIT : FILL;
      WAIT:       w_state_nx = w_go ? (w_last_frame ? DRAIN : FILL) : WAIT;
      DRAIN:      w_state_nx = frame_done ? DONE : DRAIN;
      default:    w_state_nx = IDLE;
    endcase
  end
  // command shifter, bit/frame counters, one-deep frame_done pending flag and sticky errors
  always_ff @(posedge CLK_40) begin
    if (reset) begin
      r_shift     <= '0;
      r_bit_cnt   <= '0;
      r_frame_idx <= '0;
      r_pending   <= 1'b0;
      r_overrun   <= 1'b0;
      r_len_err   <= 1'b0;
    end else begin
      r_shift     <= w_start ? {READ_CMD, START_ADDR} : w_fall_en ? r_shift << 1 : r_shift;
      r_bit_cnt   <= (w_start || w_cmd_end || w_next_frame) ? '0 : SPI_clk_en ? r_bit_cnt + 1'b1 : r_bit_cnt;
      r_frame_idx <= w_start ? '0 : w_next_frame ? r_frame_idx + 1'b1 : r_frame_idx;
      r_pending   <= (r_state == FILL && frame_done) ? 1'b1 : (w_start || w_go) ? 1'b0 : r_pending;
      r_overrun   <= r_overrun || (r_state == FILL && frame_done);
      r_len_err   <= r_len_err || w_short;
    end
  end
  assign CS_N          = !(r_state == CMD || r_state == FILL || r_state == WAIT);
  assign MOSI          = r_shift[31];
  assign video_bank_we = r_state == FILL;
  assign frame_idx     = r_frame_idx;
  assign busy          = !(r_state == IDLE || r_state == DONE);
  assign done          = r_state == DONE;
  assign overrun       = r_overrun;
  assign len_err       = r_len_err;
endmodule
